// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Tracks an in-flight multiply; strobes the HI/LO write in its last busy cycle.
module mul_sequencer #(
    parameter int MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic we_hilo_i,
    output logic mul_busy_o,
    output logic hilo_we_o
);

    logic [3:0] cnt_q, cnt_d;

    // An issue while busy is dropped; the D-stage stall keeps that from happening.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
        else if (we_hilo_i)
            cnt_d = 4'(MUL_LATENCY - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 4'd0;
        else      cnt_q <= cnt_d;
    end

    assign mul_busy_o = (cnt_q != 4'd0);
    assign hilo_we_o  = (cnt_q == 4'd1);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, stall/flush enables, multiply sequencing.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic [4:0]       rf_wa_E,
    input  logic [4:0]       rf_wa_M,
    input  logic [4:0]       rf_wa_W,
    input  logic             we_reg_E,
    input  logic             we_reg_M,
    input  logic             we_reg_W,
    input  logic             dm2reg_E,
    input  logic             dm2reg_M,
    input  logic             branch_D,
    input  logic             reg_jump_D,
    input  logic             jump_D,
    input  logic             branch_taken_D,
    input  logic             hilo_rd_D,
    input  logic             mul_D,
    input  logic             we_hilo_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             fwd_a_D,
    output logic             fwd_b_D,
    output logic [1:0]       fwd_a_E,
    output logic [1:0]       fwd_b_E,
    output logic             mul_busy,
    output logic             hilo_we,
    output logic [CNT_W-1:0] stall_count
);

    logic lw_stall, br_stall, mul_stall, stall;
    logic [CNT_W-1:0] stall_count_q;

    mul_sequencer #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .we_hilo_i  (we_hilo_E),
        .mul_busy_o (mul_busy),
        .hilo_we_o  (hilo_we)
    );

    // M-stage result is newer than W, so it wins.
    always_comb begin
        fwd_a_E = FWD_RF;
        fwd_b_E = FWD_RF;
        if (we_reg_M && reg_hit(rs_E, rf_wa_M))      fwd_a_E = FWD_M;
        else if (we_reg_W && reg_hit(rs_E, rf_wa_W)) fwd_a_E = FWD_W;
        if (we_reg_M && reg_hit(rt_E, rf_wa_M))      fwd_b_E = FWD_M;
        else if (we_reg_W && reg_hit(rt_E, rf_wa_W)) fwd_b_E = FWD_W;
    end

    assign fwd_a_D = we_reg_M && reg_hit(rs_D, rf_wa_M);
    assign fwd_b_D = we_reg_M && reg_hit(rt_D, rf_wa_M);

    assign lw_stall = dm2reg_E && we_reg_E &&
                      (reg_hit(rs_D, rf_wa_E) || reg_hit(rt_D, rf_wa_E));

    // The D-stage comparator cannot see E results or M load data.
    always_comb begin
        br_stall = 1'b0;
        if (branch_D)
            br_stall = (we_reg_E && (reg_hit(rs_D, rf_wa_E) || reg_hit(rt_D, rf_wa_E))) ||
                       (dm2reg_M && (reg_hit(rs_D, rf_wa_M) || reg_hit(rt_D, rf_wa_M)));
        else if (reg_jump_D)
            br_stall = (we_reg_E && reg_hit(rs_D, rf_wa_E)) ||
                       (dm2reg_M && reg_hit(rs_D, rf_wa_M));
    end

    assign mul_stall = (hilo_rd_D || mul_D) && (mul_busy || we_hilo_E);
    assign stall     = lw_stall || br_stall || mul_stall;

    assign stall_F = stall;
    assign stall_D = stall;
    assign flush_E = stall;
    assign flush_D = ((branch_D && branch_taken_D) || jump_D || reg_jump_D) && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count_q <= '0;
        else if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_q <= stall_count_q + CNT_W'(1);
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed table, multiply/reset/saturation sequences, random vs model.
module tb_hazard_unit;

    localparam int L = 4;

    typedef struct {
        logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W;
        logic we_E, we_M, we_W, dm_E, dm_M, br, rj, j, bt, hrd, mul, whe;
    } in_t;

    typedef struct {
        logic [1:0] fa_E, fb_E;
        logic fa_D, fb_D, stall, flush;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    in_t cur, zero_in;

    logic stall_F, stall_D, flush_D, flush_E, fwd_a_D, fwd_b_D, mul_busy, hilo_we;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic [31:0] stall_count;
    logic s4_F, s4_D, f4_D, f4_E, fa4_D, fb4_D, busy4, hwe4;
    logic [1:0] fa4_E, fb4_E;
    logic [3:0] stall_count4;

    hazard_unit #(.MUL_LATENCY(L), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs_D(cur.rs_D), .rt_D(cur.rt_D), .rs_E(cur.rs_E), .rt_E(cur.rt_E),
        .rf_wa_E(cur.wa_E), .rf_wa_M(cur.wa_M), .rf_wa_W(cur.wa_W),
        .we_reg_E(cur.we_E), .we_reg_M(cur.we_M), .we_reg_W(cur.we_W),
        .dm2reg_E(cur.dm_E), .dm2reg_M(cur.dm_M), .branch_D(cur.br), .reg_jump_D(cur.rj),
        .jump_D(cur.j), .branch_taken_D(cur.bt), .hilo_rd_D(cur.hrd), .mul_D(cur.mul),
        .we_hilo_E(cur.whe), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .flush_E(flush_E), .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .fwd_a_E(fwd_a_E),
        .fwd_b_E(fwd_b_E), .mul_busy(mul_busy), .hilo_we(hilo_we), .stall_count(stall_count)
    );

    hazard_unit #(.MUL_LATENCY(L), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rs_D(cur.rs_D), .rt_D(cur.rt_D), .rs_E(cur.rs_E), .rt_E(cur.rt_E),
        .rf_wa_E(cur.wa_E), .rf_wa_M(cur.wa_M), .rf_wa_W(cur.wa_W),
        .we_reg_E(cur.we_E), .we_reg_M(cur.we_M), .we_reg_W(cur.we_W),
        .dm2reg_E(cur.dm_E), .dm2reg_M(cur.dm_M), .branch_D(cur.br), .reg_jump_D(cur.rj),
        .jump_D(cur.j), .branch_taken_D(cur.bt), .hilo_rd_D(cur.hrd), .mul_D(cur.mul),
        .we_hilo_E(cur.whe), .stall_F(s4_F), .stall_D(s4_D), .flush_D(f4_D),
        .flush_E(f4_E), .fwd_a_D(fa4_D), .fwd_b_D(fb4_D), .fwd_a_E(fa4_E),
        .fwd_b_E(fb4_E), .mul_busy(busy4), .hilo_we(hwe4), .stall_count(stall_count4)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: stall totals as plain integers, multiply as an issue cycle number.
    int sc, mcyc, issue_at;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit dep(logic [4:0] src, logic [4:0] dst);
        return (src != 0) && (src == dst);
    endfunction

    function automatic bit m_busy();
        return (mcyc > issue_at) && (mcyc <= issue_at + L - 1);
    endfunction

    function automatic bit m_hilo();
        return mcyc == issue_at + L - 1;
    endfunction

    function automatic exp_t model(in_t x);
        exp_t e;
        bit lw, brs, ms;
        logic [4:0] srcs[2];
        srcs[0] = x.rs_D;
        srcs[1] = x.rt_D;
        e.fa_E = (x.we_M && dep(x.rs_E, x.wa_M)) ? 2'd2 : (x.we_W && dep(x.rs_E, x.wa_W)) ? 2'd1 : 2'd0;
        e.fb_E = (x.we_M && dep(x.rt_E, x.wa_M)) ? 2'd2 : (x.we_W && dep(x.rt_E, x.wa_W)) ? 2'd1 : 2'd0;
        e.fa_D = x.we_M && dep(x.rs_D, x.wa_M);
        e.fb_D = x.we_M && dep(x.rt_D, x.wa_M);
        lw = 0;
        brs = 0;
        foreach (srcs[k]) begin
            if (x.dm_E && x.we_E && dep(srcs[k], x.wa_E)) lw = 1;
            if ((x.br || (x.rj && k == 0)) &&
                ((x.we_E && dep(srcs[k], x.wa_E)) || (x.dm_M && dep(srcs[k], x.wa_M)))) brs = 1;
        end
        ms = (x.hrd || x.mul) && (m_busy() || x.whe);
        e.stall = lw || brs || ms;
        e.flush = ((x.br && x.bt) || x.j || x.rj) && !e.stall;
        return e;
    endfunction

    task automatic step(string tag);
        exp_t e;
        e = model(cur);
        @(negedge clk);
        chk({tag, ".stall_F"}, stall_F, e.stall);
        chk({tag, ".stall_D"}, stall_D, e.stall);
        chk({tag, ".flush_E"}, flush_E, e.stall);
        chk({tag, ".flush_D"}, flush_D, e.flush);
        chk({tag, ".fwd_a_E"}, fwd_a_E, e.fa_E);
        chk({tag, ".fwd_b_E"}, fwd_b_E, e.fb_E);
        chk({tag, ".fwd_a_D"}, fwd_a_D, e.fa_D);
        chk({tag, ".fwd_b_D"}, fwd_b_D, e.fb_D);
        chk({tag, ".mul_busy"}, mul_busy, m_busy());
        chk({tag, ".hilo_we"}, hilo_we, m_hilo());
        chk({tag, ".count"}, stall_count, sc);
        chk({tag, ".count4"}, stall_count4, (sc > 15) ? 15 : sc);
        @(posedge clk);
        if (e.stall) sc++;
        if (cur.whe && !m_busy()) issue_at = mcyc;
        mcyc++;
        #1;
    endtask

    task automatic do_reset();
        cur = zero_in;
        rst = 1'b0;
        #2;
        chk("rst.outs", {stall_F, stall_D, flush_D, flush_E, fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, mul_busy, hilo_we}, 0);
        chk("rst.count", stall_count, 0);
        chk("rst.count4", stall_count4, 0);
        sc = 0;
        issue_at = -100;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic mul_seq(string tag);
        int start;
        bit st_e[5] = '{1, 1, 1, 1, 0};
        bit bz_e[5] = '{0, 1, 1, 1, 0};
        bit hw_e[5] = '{0, 0, 0, 1, 0};
        start = sc;
        for (int k = 0; k < 5; k++) begin
            cur = zero_in;
            cur.hrd = 1'b1;
            cur.whe = (k == 0);
            #1;
            chk($sformatf("%s.stall%0d", tag, k), stall_D, st_e[k]);
            chk($sformatf("%s.busy%0d", tag, k), mul_busy, bz_e[k]);
            chk($sformatf("%s.hilo%0d", tag, k), hilo_we, hw_e[k]);
            step(tag);
        end
        chk({tag, ".count"}, stall_count, start + 4);
    endtask

    always @(negedge clk)
        if (rst && cur.whe && mul_busy)
            assert (0) else $error("FAIL we_hilo_E while busy");

    vec_t tbl[14];

    function automatic in_t mk(logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W,
                               logic [12:0] f);
        in_t x;
        {x.rs_D, x.rt_D, x.rs_E, x.rt_E, x.wa_E, x.wa_M, x.wa_W} = {rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W};
        {x.we_E, x.we_M, x.we_W, x.dm_E, x.dm_M, x.br, x.rj, x.j, x.bt, x.hrd, x.mul, x.whe} = f[11:0];
        return x;
    endfunction

    function automatic exp_t ex(logic [1:0] fa_E, fb_E, logic fa_D, fb_D, stall, flush);
        exp_t e;
        e.fa_E = fa_E; e.fb_E = fb_E; e.fa_D = fa_D; e.fb_D = fb_D; e.stall = stall; e.flush = flush;
        return e;
    endfunction

    // flag order: we_E we_M we_W dm_E dm_M br rj j bt hrd mul whe
    initial begin
        zero_in = mk(0, 0, 0, 0, 0, 0, 0, 13'b0);
        cur = zero_in;
        mcyc = 0;
        tbl[0]  = '{mk(0, 0, 3, 0, 0, 3, 3, 13'b0_011_00_000_0000), ex(2, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk(0, 0, 3, 0, 0, 3, 3, 13'b0_001_00_000_0000), ex(1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 13'b0_011_00_000_0000), ex(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mk(0, 0, 9, 6, 0, 9, 6, 13'b0_011_00_000_0000), ex(2, 1, 0, 0, 0, 0)};
        tbl[4]  = '{mk(0, 5, 0, 0, 5, 0, 0, 13'b0_100_10_000_0000), ex(0, 0, 0, 0, 1, 0)};
        tbl[5]  = '{mk(0, 5, 0, 0, 5, 0, 0, 13'b0_000_10_000_0000), ex(0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{mk(7, 0, 0, 0, 7, 0, 0, 13'b0_100_00_100_1000), ex(0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{mk(7, 0, 0, 0, 0, 7, 0, 13'b0_010_00_100_1000), ex(0, 0, 1, 0, 0, 1)};
        tbl[8]  = '{mk(0, 8, 0, 0, 0, 8, 0, 13'b0_010_01_100_1000), ex(0, 0, 0, 1, 1, 0)};
        tbl[9]  = '{mk(2, 9, 0, 0, 9, 0, 0, 13'b0_100_00_010_0000), ex(0, 0, 0, 0, 0, 1)};
        tbl[10] = '{mk(9, 0, 0, 0, 9, 0, 0, 13'b0_100_00_010_0000), ex(0, 0, 0, 0, 1, 0)};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 13'b0_000_00_001_0000), ex(0, 0, 0, 0, 0, 1)};
        tbl[12] = '{mk(4, 4, 0, 0, 0, 0, 0, 13'b0_000_00_100_0000), ex(0, 0, 0, 0, 0, 0)};
        tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 13'b0_000_00_000_0010), ex(0, 0, 0, 0, 0, 0)};

        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) begin
            cur = tbl[i].in;
            #1;
            chk($sformatf("tbl%0d.fwd_a_E", i), fwd_a_E, tbl[i].ex.fa_E);
            chk($sformatf("tbl%0d.fwd_b_E", i), fwd_b_E, tbl[i].ex.fb_E);
            chk($sformatf("tbl%0d.fwd_a_D", i), fwd_a_D, tbl[i].ex.fa_D);
            chk($sformatf("tbl%0d.fwd_b_D", i), fwd_b_D, tbl[i].ex.fb_D);
            chk($sformatf("tbl%0d.stall", i), {stall_F, stall_D, flush_E}, {3{tbl[i].ex.stall}});
            chk($sformatf("tbl%0d.flush_D", i), flush_D, tbl[i].ex.flush);
            step($sformatf("tbl%0d", i));
        end

        do_reset();
        mul_seq("mul");

        // Abandon a multiply with an async reset in its third cycle.
        do_reset();
        cur = zero_in; cur.hrd = 1'b1; cur.whe = 1'b1;
        step("mrst0");
        cur.whe = 1'b0;
        step("mrst1");
        #1 rst = 1'b0;
        #1;
        chk("mrst.busy", mul_busy, 0);
        chk("mrst.hilo", hilo_we, 0);
        chk("mrst.count", stall_count, 0);
        sc = 0;
        issue_at = -100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst.hold_hilo%0d", k), hilo_we, 0);
            chk($sformatf("mrst.hold_busy%0d", k), mul_busy, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        mul_seq("mul2");

        do_reset();
        cur = tbl[4].in;
        for (int k = 0; k < 20; k++) step("sat");
        chk("sat.count4", stall_count4, 15);
        chk("sat.count", stall_count, 20);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            cur.rs_D = 5'($urandom_range(0, 3)); cur.rt_D = 5'($urandom_range(0, 3));
            cur.rs_E = 5'($urandom_range(0, 3)); cur.rt_E = 5'($urandom_range(0, 3));
            cur.wa_E = 5'($urandom_range(0, 3)); cur.wa_M = 5'($urandom_range(0, 3));
            cur.wa_W = 5'($urandom_range(0, 3));
            {cur.we_E, cur.we_M, cur.we_W, cur.dm_E, cur.dm_M} = 5'($urandom);
            {cur.br, cur.rj, cur.j, cur.bt} = 4'($urandom) & ($urandom_range(0, 1) ? 4'b1001 : 4'b0111);
            cur.hrd = ($urandom_range(0, 3) == 0);
            cur.mul = ($urandom_range(0, 5) == 0);
            cur.whe = ($urandom_range(0, 4) == 0) && !m_busy();
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard and sequencing controller for the 5-stage pipelined MIPS datapath (F/D/E/M/W).
- Generates stall and flush enables for the pipeline registers, forwarding selects for the D-stage branch comparator and the E-stage ALU operands, and sequences the multi-cycle multiplier that writes HI/LO.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LATENCY, 4, cycles from multiply issue in E to HI/LO write; legal range 2..15.
- CNT_W, 32, width of the stall_count counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rs_D, rt_D  in  5  source register addresses in D
- rs_E, rt_E  in  5  source register addresses in E
- rf_wa_E, rf_wa_M, rf_wa_W  in  5  destination addresses in E/M/W
- we_reg_E, we_reg_M, we_reg_W  in  1  register write enables in E/M/W
- dm2reg_E, dm2reg_M  in  1  load flags in E/M
- branch_D, reg_jump_D, jump_D  in  1  control-flow class of the D instruction
- branch_taken_D  in  1  D-stage comparator result
- hilo_rd_D  in  1  D instruction is mfhi/mflo
- mul_D  in  1  D instruction is a multiply
- we_hilo_E  in  1  multiply issuing in E
- stall_F, stall_D  out  1  hold PC / IF-ID register
- flush_D, flush_E  out  1  clear IF-ID / ID-EX register
- fwd_a_D, fwd_b_D  out  1  1 = forward alu_out_M into the comparator
- fwd_a_E, fwd_b_E  out  2  00 = register file, 01 = wd_rf (W), 10 = alu_out_M
- mul_busy  out  1  multiplier occupied
- hilo_we  out  1  one-cycle HI/LO write strobe
- stall_count  out  CNT_W  total stalled cycles

Behaviour:
- Register address 0 never matches in any compare below.
- fwd_a_E:
  - 10 if rs_E==rf_wa_M and we_reg_M.
  - Otherwise 01 if rs_E==rf_wa_W and we_reg_W.
  - Otherwise 00.
  - M has priority over W.
  - fwd_b_E uses the same rule with rt_E.
- fwd_a_D = (rs_D==rf_wa_M and we_reg_M). fwd_b_D uses the same rule with rt_D.
- lw_stall = dm2reg_E and we_reg_E and rf_wa_E in {rs_D, rt_D}.
- br_stall:
  - For branch_D: (we_reg_E and rf_wa_E in {rs_D, rt_D}) or (dm2reg_M and rf_wa_M in {rs_D, rt_D}).
  - For reg_jump_D: the same conditions, comparing rs_D only.
- mul_stall = (hilo_rd_D or mul_D) and (mul_busy or we_hilo_E).
- stall = lw_stall | br_stall | mul_stall.
  - stall_F = stall_D = flush_E = stall.
- flush_D = ((branch_D and branch_taken_D) or jump_D or reg_jump_D) and not stall.
- Multiply sequencer: 4-bit down-counter cnt.
  - When we_hilo_E and cnt==0: cnt loads MUL_LATENCY-1 at the clock edge.
  - When cnt!=0: cnt decrements each edge.
  - mul_busy = (cnt!=0).
  - hilo_we = (cnt==1), combinational.
  - Issue at cycle t gives: busy during t+1..t+L-1, hilo_we in cycle t+L-1, HI/LO readable in cycle t+L.
- we_hilo_E while mul_busy cannot occur by construction (mul_stall). If it does, it is ignored; the bench flags it with an assertion.
- stall_count increments by 1 on every edge where stall=1. It saturates at all-ones and does not wrap.
- Reset (rst=0, asynchronous):
  - cnt=0 and stall_count=0 immediately, hence mul_busy=0 and hilo_we=0.
  - Reset mid-multiply abandons the operation: no hilo_we pulse.
  - With all inputs 0, every output is 0.
- Simultaneous events:
  - A taken branch together with a stall yields flush_D=0: the branch re-evaluates next cycle.
  - A load-use hazard and a multiply hazard together produce one stall cycle per cycle. Both are counted once.

Decomposition:
- Shared package mips_pkg:
  - forwarding select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - register-zero constant.
- One natural sub-module, mul_sequencer: cnt, mul_busy, hilo_we.
- Forwarding and stall logic stay flat in hazard_unit.

Test Plan:
- ALU-ALU forwarding: rs_E=3, rf_wa_M=3, we_reg_M=1, rf_wa_W=3, we_reg_W=1 -> fwd_a_E=10. Then drop we_reg_M -> fwd_a_E=01. With rs_E=0 and all writes matching 0 -> 00.
- Load-use: dm2reg_E=we_reg_E=1, rf_wa_E=5, rt_D=5 -> stall_F=stall_D=flush_E=1 for exactly one cycle; stall_count 0->1.
- Branch hazards:
  - branch_D=1, rs_D=7, rf_wa_E=7, we_reg_E=1, branch_taken_D=1 -> stall=1, flush_D=0.
  - Next cycle, inputs moved to M (non-load) -> stall=0, fwd_a_D=1, flush_D=1.
- Multiply, MUL_LATENCY=4: we_hilo_E pulse at cycle 0 with hilo_rd_D=1 held -> stall in cycles 0..3, mul_busy in 1..3, hilo_we in cycle 3 only, stall=0 in cycle 4; stall_count=4.
- Reset mid-multiply: rst low in cycle 2 after issue -> mul_busy=0 immediately, no hilo_we, stall_count=0. After release, a new multiply runs a full 4-cycle sequence.
- Saturation, CNT_W=4: hold lw_stall for 20 cycles -> stall_count reaches 15 and holds at 15.
